ram_fifo_ctrl: RTL and testbench
================================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, reset, sampled on the rising edge of clk.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- push  in  1  write request
- push_data  in  8  byte to enqueue
- push_ready  out  1  push accepted this cycle
- pop  in  1  read request
- pop_valid  out  1  pop_data valid (one-cycle pulse)
- pop_data  out  8  dequeued byte
- count  out  5  occupancy, 0..16
- full  out  1  count==16
- empty  out  1  count==0
- overflow  out  1  sticky: push while full
- underflow  out  1  sticky: pop while empty
- ram_addr  out  4  to RAM addr
- ram_data_in  out  8  to RAM data_in
- ram_write_enable  out  1  to RAM write_enable
- ram_data_out  in  8  from RAM data_out

Function
REQ-003 The block SHALL implement a 16-entry byte FIFO on a single-port 16x8 RAM; the RAM writes on a clk edge with write_enable=1 and presents the addressed byte on ram_data_out one clock after the address.
REQ-004 The state machine SHALL have two states: IDLE and RD_WAIT.
REQ-005 In IDLE with pop=1 and empty=0 the block SHALL do all of the following:
- drive ram_addr=rd_ptr and ram_write_enable=0;
- increment rd_ptr and decrement count at the clock edge;
- enter RD_WAIT.
REQ-006 In RD_WAIT the block SHALL register ram_data_out into pop_data, set pop_valid=1 for the next cycle only, and return to IDLE.
REQ-007 push_ready SHALL equal (state==IDLE) AND NOT full AND NOT (pop AND NOT empty), combinationally.
REQ-008 When push=1 and push_ready=1 the block SHALL do all of the following:
- drive ram_addr=wr_ptr, ram_data_in=push_data and ram_write_enable=1 in that cycle;
- increment wr_ptr and count at the clock edge.
REQ-009 If push and a valid pop occur together in IDLE, the pop SHALL win and the push SHALL NOT be accepted; the requester retries.
REQ-010 When no write is in progress, ram_write_enable SHALL be 0, ram_addr SHALL equal rd_ptr and ram_data_in SHALL equal push_data.
REQ-011 wr_ptr and rd_ptr SHALL be 4 bits wide and SHALL wrap 15->0 without any flag.
REQ-012 full SHALL equal (count==16) and empty SHALL equal (count==0), decoded from count.
REQ-013 A push while full SHALL write nothing and change no pointer; a pop while empty SHALL change no state and SHALL produce no pop_valid.
REQ-014 A pop request in RD_WAIT SHALL be ignored; one pop is accepted at most every 2 cycles.
REQ-015 Accepted-pop to pop_valid latency SHALL be 2 clocks; push to stored SHALL be 1 clock.

Reset
REQ-016 While reset=1, the block SHALL hold:
- state=IDLE;
- wr_ptr=0, rd_ptr=0, count=0;
- pop_valid=0, pop_data=8'h00;
- overflow=0, underflow=0;
- ram_write_enable=0 (forced, regardless of push).
REQ-017 Reset asserted in RD_WAIT SHALL abort the read with no pop_valid; all FIFO contents SHALL be logically discarded.

Configuration
REQ-018 With RAM_FIFO_ERR_EN defined, overflow SHALL set on push&&full and underflow on pop&&empty&&state==IDLE; both SHALL clear only on reset.
REQ-019 Without RAM_FIFO_ERR_EN, the overflow and underflow ports SHALL exist and SHALL be tied to 0.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset, then push 8'hAA -> ram_addr=0, ram_write_enable=1 that cycle; count=1, empty=0.
- Push 8'hAA then 8'h55, then pop twice -> pop_data=8'hAA, then 8'h55, each 2 clocks after the pop; count=0.
- Push 16 bytes 8'h00..8'h0F -> full=1, push_ready=0; a 17th push gives overflow=1 (with macro) and count stays 16.
- 20 push/pop cycles -> pointers wrap 15->0 and data order is preserved.
- push=1 and pop=1 with count=3 -> push_ready=0, pop served, count=2.
- reset asserted in RD_WAIT -> no pop_valid, count=0; pop on empty -> underflow=1 (with macro).

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: 16-entry byte FIFO controller driving a single-port 16x8 synchronous-read RAM.
// Define RAM_FIFO_ERR_EN to enable sticky overflow/underflow flags (tied to 0 otherwise).
module ram_fifo_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       push_ready,
  input  logic       pop,
  output logic       pop_valid,
  output logic [7:0] pop_data,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       underflow,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_data_in,
  output logic       ram_write_enable,
  input  logic [7:0] ram_data_out
);
  typedef enum logic {IDLE, RD_WAIT} state_t;
  state_t state, state_nxt;
  logic [3:0] wr_ptr, rd_ptr;
  logic pop_acc, push_acc;
  assign full = count == 5'd16;
  assign empty = count == 5'd0;
  assign pop_acc = state == IDLE && pop && !empty;
  assign push_ready = state == IDLE && !full && !(pop && !empty);
  assign push_acc = push && push_ready;
  assign ram_addr = push_acc ? wr_ptr : rd_ptr;
  assign ram_data_in = push_data;
  assign ram_write_enable = push_acc && !reset;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (pop_acc ? RD_WAIT : IDLE) : IDLE;
  end
  // RAM output is valid during RD_WAIT, one clock after the read address
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr    <= 4'd0;
      rd_ptr    <= 4'd0;
      count     <= 5'd0;
      pop_valid <= 1'b0;
      pop_data  <= 8'h00;
    end else begin
      pop_valid <= state == RD_WAIT;
      if (state == RD_WAIT) pop_data <= ram_data_out;
      if (push_acc) wr_ptr <= wr_ptr + 4'd1;
      if (pop_acc) rd_ptr <= rd_ptr + 4'd1;
      count <= count + {4'd0, push_acc} - {4'd0, pop_acc};
    end
`ifdef RAM_FIFO_ERR_EN
  always_ff @(posedge clk)
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full) overflow <= 1'b1;
      if (pop && empty && state == IDLE) underflow <= 1'b1;
    end
`else
  assign overflow = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed bench for ram_fifo_ctrl with a behavioural 16x8 RAM and a queue reference.
module tb_ram_fifo_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1, push = 1'b0, pop = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic push_ready, pop_valid, full, empty, overflow, underflow, ram_write_enable;
  logic [7:0] pop_data, ram_data_in, ram_data_out;
  logic [4:0] count;
  logic [3:0] ram_addr;
  logic [7:0] mem [16];
  logic [7:0] q [$];
  int vecs = 0, errs = 0;
`ifdef RAM_FIFO_ERR_EN
  logic err_exp = 1'b1;
`else
  logic err_exp = 1'b0;
`endif
  always #5 clk = ~clk;
  ram_fifo_ctrl dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data), .push_ready(push_ready),
    .pop(pop), .pop_valid(pop_valid), .pop_data(pop_data), .count(count), .full(full),
    .empty(empty), .overflow(overflow), .underflow(underflow), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end
  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_byte(input logic [7:0] d);
    push = 1'b1;
    push_data = d;
    #1 chk("push_ready", push_ready, 1);
    q.push_back(d);
    @(negedge clk) push = 1'b0;
  endtask
  task automatic pop_byte(input string tag);
    logic [7:0] e;
    e = q.pop_front();
    pop = 1'b1;
    #1 chk({tag, "_we"}, ram_write_enable, 0);
    @(negedge clk) pop = 1'b0;
    chk({tag, "_valid_early"}, pop_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, pop_valid, 1);
    chk({tag, "_data"}, pop_data, e);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    push = 1'b1;
    #1 chk("rst_we_forced", ram_write_enable, 0);
    push = 1'b0;
    reset = 1'b0;
    push = 1'b1;
    push_data = 8'hAA;
    #1 chk("push_addr", ram_addr, 0);
    chk("push_we", ram_write_enable, 1);
    chk("push_din", ram_data_in, 8'hAA);
    q.push_back(8'hAA);
    @(negedge clk) push = 1'b0;
    chk("push_count", count, 1);
    chk("push_empty", empty, 0);
    #1 chk("idle_we", ram_write_enable, 0);
    chk("idle_addr", ram_addr, 0);
    push_byte(8'h55);
    chk("two_count", count, 2);
    pop_byte("pop_aa");
    pop_byte("pop_55");
    chk("drain_count", count, 0);
    chk("drain_empty", empty, 1);
    do_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("full_count", count, 16);
    chk("full_flag", full, 1);
    chk("full_ready", push_ready, 0);
    push = 1'b1;
    push_data = 8'hFF;
    #1 chk("ovf_we", ram_write_enable, 0);
    @(negedge clk) push = 1'b0;
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, err_exp);
    for (int i = 0; i < 16; i++) pop_byte("full_drain");
    chk("full_drain_count", count, 0);
    for (int i = 0; i < 3; i++) push_byte(8'h80 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      push_byte(8'h30 + 8'(i));
      pop_byte("wrap");
    end
    chk("wrap_count", count, 3);
    push = 1'b1;
    pop = 1'b1;
    push_data = 8'hEE;
    #1 chk("both_ready", push_ready, 0);
    chk("both_we", ram_write_enable, 0);
    @(negedge clk) begin push = 1'b0; pop = 1'b0; end
    chk("both_count", count, 2);
    @(negedge clk);
    chk("both_valid", pop_valid, 1);
    chk("both_data", pop_data, q.pop_front());
    pop = 1'b1;
    @(negedge clk) begin pop = 1'b0; reset = 1'b1; end
    @(negedge clk) reset = 1'b0;
    q.delete();
    chk("abort_valid", pop_valid, 0);
    chk("abort_count", count, 0);
    chk("abort_ovf_clr", overflow, 0);
    @(negedge clk);
    chk("abort_valid_late", pop_valid, 0);
    pop = 1'b1;
    #1 chk("unf_ready", push_ready, 1);
    @(negedge clk) pop = 1'b0;
    chk("unf_flag", underflow, err_exp);
    chk("unf_count", count, 0);
    @(negedge clk);
    chk("unf_no_valid", pop_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
